bus_breakout_pipe: RTL and testbench

BUS_BREAKOUT_PIPE -- requirements
Module: bus_breakout_pipe

---
 rtl/bus_breakout_pkg.sv | 26 ++
 rtl/bus_breakout_fmt.sv | 32 +++
 rtl/bus_breakout_pipe.sv | 128 ++++++++++++
 tb/tb_bus_breakout_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_breakout_pkg.sv
// Shared types for the bus breakout pipe: combine operators and buffer states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package bus_breakout_pkg;

  // Operator applied between the upper half of in_1 and the lower half of in_2.
  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Width of an assembled word for an input bus of width w.
  function automatic int unsigned out_width(input int unsigned w);
    return w + w / 2;
  endfunction

endpackage

// File: rtl/bus_breakout_fmt.sv
// Assembles {in_2 upper half, in_1 upper half <op> in_2 lower half, in_1 lower half}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the word is captured.
module bus_breakout_fmt
  import bus_breakout_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]       in_1,
  input  logic [W-1:0]       in_2,
  input  mode_e              mode,
  output logic [W+W/2-1:0]   out_word
);

  localparam int H = W / 2;

  logic [H-1:0] field;

  // Select the middle field operator and splice the three fields together.
  always_comb begin
    field = '0;
    unique case (mode)
      MODE_AND:  field = in_1[W-1:H] & in_2[H-1:0];
      MODE_OR:   field = in_1[W-1:H] | in_2[H-1:0];
      MODE_XOR:  field = in_1[W-1:H] ^ in_2[H-1:0];
      MODE_PASS: field = in_1[W-1:H];
      default:   field = '0;
    endcase
    out_word = {in_2[W-1:H], field, in_1[H-1:0]};
  end

endmodule

// File: rtl/bus_breakout_pipe.sv
// Formats two input buses into one wider word and buffers it in a 2-entry FIFO;
// latency 1 cycle from accept (in EMPTY) to out_valid; optional xfer_count under BUS_BREAKOUT_STATS_EN.
// Backpressure: in_ready is registered (low only when FULL); out_1 holds while out_valid && !out_ready.
module bus_breakout_pipe
  import bus_breakout_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_1,
  input  logic [W-1:0]       in_2,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W+W/2-1:0]   out_1,
  output logic               out_valid,
  input  logic               out_ready
`ifdef BUS_BREAKOUT_STATS_EN
  ,
  output logic [CNT_W-1:0]   xfer_count
`endif
);

  localparam int WO = int'(out_width(W));

  state_e          state_q, state_d;
  logic [WO-1:0]   head_q, head_d;
  logic [WO-1:0]   tail_q, tail_d;
  logic            in_ready_q, in_ready_d;
  logic [WO-1:0]   fmt_word;
  logic            push;
  logic            pop;

  // Words are assembled before buffering so the FIFO holds finished output.
  bus_breakout_fmt #(
    .W (W)
  ) u_fmt (
    .in_1     (in_1),
    .in_2     (in_2),
    .mode     (mode_e'(mode)),
    .out_word (fmt_word)
  );

  assign push      = in_valid && in_ready_q;
  assign pop       = (state_q != ST_EMPTY) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_1     = head_q;

  // Next occupancy and entry contents; head is always the word on out_1.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          head_d  = fmt_word;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = fmt_word;
        end else if (push) begin
          state_d = ST_FULL;
          tail_d  = fmt_word;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered so the source never sees a path from out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  // Buffer state and contents; reset clears entries so out_1 reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef BUS_BREAKOUT_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count output transfers, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_count = cnt_q;
`else
  // Counter width only matters in the statistics build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_bus_breakout_pipe.sv
// Directed bench with a scoreboard queue for the bus breakout pipe (W=4, CNT_W=4).
// Expected words are computed from the inputs at accept time and compared at delivery.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_breakout_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_1;
  logic [3:0] in_2;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out_1;
  logic       out_valid;
  logic       out_ready;
`ifdef BUS_BREAKOUT_STATS_EN
  logic [3:0] xfer_count;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  int         cnt_m = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  bus_breakout_pipe #(
    .W     (4),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_1       (in_1),
    .in_2       (in_2),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_1      (out_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef BUS_BREAKOUT_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] m);
    logic [1:0] f;
    case (m)
      2'd0:    f = a[3:2] & b[1:0];
      2'd1:    f = a[3:2] | b[1:0];
      2'd2:    f = a[3:2] ^ b[1:0];
      default: f = a[3:2];
    endcase
    return {b[3:2], f, a[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: settle scoreboard for the coming edge, then advance to the next falling edge.
  task automatic cycle();
    logic [5:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_spurious_word", 32'(out_1), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(out_1), 32'(e));
        end
        if (cnt_m < 15) cnt_m++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_1, in_2, mode));
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    in_1 = a;
    in_2 = b;
    mode = m;
    in_valid = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && out_valid; i++) cycle();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_1      = '0;
    in_2      = '0;
    mode      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_1", 32'(out_1), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef BUS_BREAKOUT_STATS_EN
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
`endif
    rst = 1'b0;
    cnt_m = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // AND: F, A -> 2B one cycle after accept
    out_ready = 1'b1;
    offer(4'hF, 4'hA, 2'd0);
    cycle();
    in_valid = 1'b0;
    chk("and_out_valid", 32'(out_valid), 32'd1);
    chk("and_out_1", 32'(out_1), 32'h2B);
    cycle();
    chk("and_done", 32'(out_valid), 32'd0);

    // XOR then PASS on the same operands
    offer(4'hF, 4'hA, 2'd2);
    cycle();
    chk("xor_out_1", 32'(out_1), 32'h27);
    offer(4'hF, 4'hA, 2'd3);
    cycle();
    in_valid = 1'b0;
    chk("pass_out_1", 32'(out_1), 32'h2F);
    drain();

    // Backpressure: three offered, two accepted, FULL holds head
    out_ready = 1'b0;
    offer(4'h1, 4'h2, 2'd1);
    cycle();
    offer(4'h5, 4'h6, 2'd2);
    cycle();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    offer(4'h9, 4'hC, 2'd0);
    cycle();
    chk("full_hold_in_ready", 32'(in_ready), 32'd0);
    chk("full_hold_out_1", 32'(out_1), 32'(model(4'h1, 4'h2, 2'd1)));
    chk("full_sb_depth", 32'(sb.size()), 32'd2);
    out_ready = 1'b1;
    cycle();
    chk("release_in_ready", 32'(in_ready), 32'd1);
    cycle();
    drain();

    // Steady push+pop in ONE for 10 cycles
    out_ready = 1'b0;
    offer(4'h3, 4'h4, 2'd0);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(4'(i), 4'(15 - i), 2'(i));
      cycle();
      chk("one_out_valid", 32'(out_valid), 32'd1);
      chk("one_in_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Reset while FULL discards both words
    out_ready = 1'b0;
    offer(4'hE, 4'h7, 2'd1);
    cycle();
    offer(4'hB, 4'hD, 2'd2);
    cycle();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    cnt_m = 0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_1", 32'(out_1), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale_word", 32'(out_valid), 32'd0);
    end

    // 20 back-to-back transfers with varying data
    for (int i = 0; i < 20; i++) begin
      offer(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
      cycle();
    end
    drain();
`ifdef BUS_BREAKOUT_STATS_EN
    chk("xfer_count_model", 32'(xfer_count), 32'(cnt_m));
    chk("xfer_count_sat", 32'(xfer_count), 32'd15);
`endif

    // Random traffic with random sink stalls
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(1));
      if (!in_valid || in_ready) begin
        if ($urandom_range(3) != 0)
          offer(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
        else
          in_valid = 1'b0;
      end
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
